// File: rtl/fifo_share_ctrl_if.sv
// fifo_share_ctrl_if
//   Bundles the producer, consumer and FIFO-side signals of fifo_share_ctrl.
//   master : environment side (producers, consumer, FIFO read data)
//   slave  : the controller
// Signals
//   req_valid/req_data/req_ready/grant_id : producer enqueue handshake
//   pop_req/pop_ready/pop_valid/pop_data  : consumer dequeue handshake
//   count/full/empty                      : committed occupancy status
//   fifo_we/fifo_en/fifo_din/fifo_dout    : FIFO control and data
interface fifo_share_ctrl_if #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*DATA_BITWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic [IDW-1:0]                   grant_id;
  logic                             pop_req;
  logic                             pop_ready;
  logic                             pop_valid;
  logic [DATA_BITWIDTH-1:0]         pop_data;
  logic [ADDR_BITWIDTH-1:0]         count;
  logic                             full;
  logic                             empty;
  logic                             fifo_we;
  logic                             fifo_en;
  logic [DATA_BITWIDTH-1:0]         fifo_din;
  logic [DATA_BITWIDTH-1:0]         fifo_dout;

  modport master (
    output req_valid, req_data, pop_req, fifo_dout,
    input  req_ready, grant_id, pop_ready, pop_valid, pop_data,
           count, full, empty, fifo_we, fifo_en, fifo_din
  );

  modport slave (
    input  req_valid, req_data, pop_req, fifo_dout,
    output req_ready, grant_id, pop_ready, pop_valid, pop_data,
           count, full, empty, fifo_we, fifo_en, fifo_din
  );
endinterface

// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl
//   Round-robin shares one FIFO enqueue port among NUM_REQ producers and
//   sequences the dequeue side for one consumer. The FIFO has no full/empty,
//   so occupancy is tracked here and writes/reads are issued only when safe.
// Ports
//   clk : clock, all state on posedge
//   rst : asynchronous reset, active-high
//   bus : fifo_share_ctrl_if.slave (producer, consumer and FIFO signals)
module fifo_share_ctrl #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_share_ctrl_if.slave bus
);
  localparam int          IDW  = $clog2(NUM_REQ);
  localparam int unsigned NREQ = NUM_REQ;

  logic [IDW-1:0]           r_rr_ptr;
  logic [ADDR_BITWIDTH-1:0] r_count;
  logic                     r_we;
  logic                     r_en;
  logic                     r_pop_valid;
  logic [DATA_BITWIDTH-1:0] r_din;

  logic [DATA_BITWIDTH-1:0] w_req_word [NUM_REQ];
  logic [IDW-1:0]           w_idx;
  logic [IDW-1:0]           w_winner;
  logic [IDW-1:0]           w_rr_next;
  logic                     w_found;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic [NUM_REQ-1:0]       w_ready;
  int unsigned              w_scan;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign w_req_word[g] = bus.req_data[g*DATA_BITWIDTH +: DATA_BITWIDTH];
  end

  // First valid requester scanning from r_rr_ptr upward, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    w_scan   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_scan = 32'(r_rr_ptr) + k;
      if (w_scan >= NREQ) w_scan = w_scan - NREQ;
      w_idx = IDW'(w_scan);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Usable capacity is DEPTH-1 (all-ones count): a full DEPTH pointer gap would read as empty.
  assign w_full    = (r_count == '1);
  assign w_empty   = (r_count == '0);
  assign w_push    = w_found & ~w_full;
  assign w_pop     = bus.pop_req & ~w_empty;
  assign w_rr_next = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_ready = '0;
    if (w_push) w_ready[w_winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_en        <= 1'b0;
      r_din       <= '0;
      r_pop_valid <= 1'b0;
      r_count     <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_we        <= w_push;
      r_en        <= w_pop;
      r_pop_valid <= r_en;
      if (w_push) begin
        r_din    <= w_req_word[w_winner];
        r_rr_ptr <= w_rr_next;
      end
      // Count leads the FIFO pointers by one cycle, so a word is poppable right after its push.
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.grant_id  = w_winner;
  assign bus.pop_ready = ~w_empty;
  assign bus.pop_valid = r_pop_valid;
  assign bus.pop_data  = bus.fifo_dout;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.fifo_we   = r_we;
  assign bus.fifo_en   = r_en;
  assign bus.fifo_din  = r_din;
endmodule
